irq_collector: RTL and testbench

Interrupt-request front end sitting directly upstream of the CPU's `i_irq`/`o_iack` pair. It edge-detects up to 64 external request lines into a pending register, gates them with a software-writable mask, and raises a single request to the CPU. During the CPU's acknowledge cycle it drives the masked pending vector onto the data path that the CPU reads instead of RAM, then clears the acknowledged bits and enforces a hold-off before re-requesting.

---
 rtl/irq_collector.sv | 142 ++++++++++++++
 tb/tb_irq_collector.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_collector.sv
`default_nettype none
// ============================================================================
//  Module      : irq_collector
//  Description : Edge-detecting, maskable interrupt collector that drives the
//                CPU irq/iack handshake and the acknowledge-cycle vector.
//                Optional macro IRQCTL_SYNC_EN adds a 2-flop input synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_collector #(
   parameter int NIRQ    = 64,
   parameter int HOLDOFF = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NIRQ-1:0] i_src,
   input  logic            i_mask_we,
   input  logic [NIRQ-1:0] i_mask,
   output logic [NIRQ-1:0] o_mask,
   input  logic            i_iack,
   output logic            o_irq,
   output logic [63:0]     o_vector,
   output logic [NIRQ-1:0] o_pending
);

   localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [CW-1:0] C_HOLD_INIT = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_ACK  = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_irq;
   logic [NIRQ-1:0] r_smp;
   logic [NIRQ-1:0] r_prev;
   logic [NIRQ-1:0] r_pend;
   logic [NIRQ-1:0] r_mask;
   logic [NIRQ-1:0] r_snap;
   logic [NIRQ-1:0] w_src;
   logic [NIRQ-1:0] w_rise;
   logic [NIRQ-1:0] w_masked;
   logic [NIRQ-1:0] w_clr;
   logic [NIRQ-1:0] w_vec;
   logic            w_capture;

`ifdef IRQCTL_SYNC_EN
   logic [NIRQ-1:0] r_sync1;
   logic [NIRQ-1:0] r_sync2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_src;
         r_sync2 <= r_sync1;
      end
   end

   assign w_src = r_sync2;
`else
   assign w_src = i_src;
`endif

   assign w_rise   = r_smp & ~r_prev;
   assign w_masked = r_pend & r_mask;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clr       = '0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|w_masked) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (i_iack) begin
               w_capture   = 1'b1;
               w_clr       = w_masked;
               w_state_nxt = S_ACK;
            end else if (~|w_masked) begin
               // only a mask write can empty the masked set while requesting
               w_state_nxt = S_IDLE;
            end
         end
         S_ACK: begin
            if (!i_iack) begin
               if (HOLDOFF == 0) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_HOLD;
                  w_cnt_nxt   = C_HOLD_INIT;
               end
            end
         end
         S_HOLD: begin
            if (r_cnt == '0) w_state_nxt = S_IDLE;
            else             w_cnt_nxt   = r_cnt - CW'(1);
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_irq   <= 1'b0;
         r_smp   <= '0;
         r_prev  <= '0;
         r_pend  <= '0;
         r_mask  <= '0;
         r_snap  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_irq   <= (w_state_nxt == S_REQ);
         r_smp   <= w_src;
         r_prev  <= r_smp;
         // a new rise on an acknowledged bit keeps it pending
         r_pend  <= (r_pend & ~w_clr) | w_rise;
         if (i_mask_we) r_mask <= i_mask;
         if (w_capture) r_snap <= w_masked;
      end
   end

   // live view before the acknowledge so the CPU sees it in the iack cycle
   assign w_vec     = ((r_state == S_IDLE) || (r_state == S_REQ)) ? w_masked : r_snap;
   assign o_vector  = 64'(w_vec);
   assign o_irq     = r_irq;
   assign o_mask    = r_mask;
   assign o_pending = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_irq_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_collector
//  Description : Directed plus randomized bench for irq_collector with a
//                behavioural model and an acknowledge-vector scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_collector;

   localparam int NIRQ    = 64;
   localparam int HOLDOFF = 4;
`ifdef IRQCTL_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic            clk = 1'b0;
   logic            reset_n;
   logic [NIRQ-1:0] i_src;
   logic            i_mask_we;
   logic [NIRQ-1:0] i_mask;
   logic [NIRQ-1:0] o_mask;
   logic            i_iack;
   logic            o_irq;
   logic [63:0]     o_vector;
   logic [NIRQ-1:0] o_pending;

   always #5 clk = ~clk;

   irq_collector #(.NIRQ(NIRQ), .HOLDOFF(HOLDOFF)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_src     (i_src),
      .i_mask_we (i_mask_we),
      .i_mask    (i_mask),
      .o_mask    (o_mask),
      .i_iack    (i_iack),
      .o_irq     (o_irq),
      .o_vector  (o_vector),
      .o_pending (o_pending)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: history of sampled lines, pending/mask sets and a
   // "earliest cycle a new request may start" timestamp.
   logic [NIRQ-1:0] hist [0:LAT];
   logic [NIRQ-1:0] m_pend, m_mask;
   logic            m_irq, m_in_ack;
   longint          cyc, m_ready_at;

   initial begin
      logic [NIRQ-1:0] rise, clr, masked;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            for (int k = 0; k <= LAT; k++) hist[k] = '0;
            m_pend = '0; m_mask = '0; m_irq = 1'b0; m_in_ack = 1'b0;
            cyc = 0; m_ready_at = 0;
         end else begin
            cyc++;
            masked = m_pend & m_mask;
            rise   = hist[LAT-1] & ~hist[LAT];
            clr    = '0;
            if (m_irq) begin
               if (i_iack) begin
                  clr = masked; m_irq = 1'b0; m_in_ack = 1'b1;
               end else if (masked == '0) begin
                  m_irq = 1'b0; m_ready_at = cyc;
               end
            end else if (m_in_ack) begin
               if (!i_iack) begin
                  m_in_ack = 1'b0; m_ready_at = cyc + HOLDOFF;
               end
            end else if (cyc > m_ready_at && masked != '0) begin
               m_irq = 1'b1;
            end
            m_pend = (m_pend & ~clr) | rise;
            if (i_mask_we) m_mask = i_mask;
            for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = i_src;
         end
      end
   end

   // Monitor: per-cycle state comparison and scoreboard pop on acknowledge
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         #2;
         check("irq", 64'(o_irq), 64'(m_irq));
         check("pending", 64'(o_pending), 64'(m_pend));
         check("mask", 64'(o_mask), 64'(m_mask));
         if (i_iack && o_irq) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL vector_unexpected: actual=%h required=<no acknowledge expected>", o_vector);
            end else begin
               e = exp_q.pop_front();
               check("vector", o_vector, e);
            end
         end
      end
   end

   task automatic set_mask(input logic [NIRQ-1:0] m);
      i_mask = m; i_mask_we = 1'b1;
      @(negedge clk);
      i_mask_we = 1'b0;
   endtask

   task automatic pulse(input logic [NIRQ-1:0] b);
      i_src = i_src | b;
      @(negedge clk);
      i_src = i_src & ~b;
   endtask

   task automatic wait_irq(input string name);
      int k = 0;
      while (!o_irq && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (!o_irq) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: o_irq=0 after 40 cycles, required 1", name);
      end
   endtask

   task automatic do_ack(input logic [63:0] exp, input int len);
      exp_q.push_back(exp);
      i_iack = 1'b1;
      repeat (len) @(negedge clk);
      i_iack = 1'b0;
   endtask

   initial begin
      int left = 0;
      int idx;
      reset_n = 1'b0; i_src = '0; i_mask = '0; i_mask_we = 1'b0; i_iack = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_irq", 64'(o_irq), 64'h0);
      check("rst_vector", o_vector, 64'h0);
      check("rst_pending", 64'(o_pending), 64'h0);
      check("rst_mask", 64'(o_mask), 64'h0);
      reset_n = 1'b1;

      // all enabled, four sources in one cycle, check latency and vector
      set_mask('1);
      i_src = 64'ha5;
      @(negedge clk);
      i_src = '0;
      repeat (LAT) @(negedge clk);
      check("t1_pending", 64'(o_pending), 64'ha5);
      check("t1_irq_early", 64'(o_irq), 64'h0);
      @(negedge clk);
      check("t1_irq_latency", 64'(o_irq), 64'h1);
      do_ack(64'ha5, 1);
      check("t1_snapshot", o_vector, 64'ha5);
      check("t1_pend_clear", 64'(o_pending), 64'h0);
      repeat (HOLDOFF + 3) @(negedge clk);

      // partial mask, then re-request exactly HOLDOFF+2 after the ack cycle
      set_mask(64'h0f);
      pulse(64'ha5);
      wait_irq("t2_irq");
      do_ack(64'h05, 1);
      check("t2_pend_left", 64'(o_pending), 64'ha0);
      set_mask('1);
      repeat (HOLDOFF) @(negedge clk);
      check("t2_irq_holdoff", 64'(o_irq), 64'h0);
      @(negedge clk);
      check("t2_irq_reassert", 64'(o_irq), 64'h1);
      do_ack(64'ha0, 1);
      repeat (HOLDOFF + 3) @(negedge clk);

      // new rise on bit 0 landing on the acknowledge edge of bit 0
      pulse(64'h1);
      wait_irq("t3_irq");
      i_src[0] = 1'b1;
      @(negedge clk);
      i_src[0] = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      do_ack(64'h1, 1);
      check("t3_bit0_kept", 64'(o_pending), 64'h1);
      wait_irq("t3_irq2");
      do_ack(64'h1, 1);
      repeat (HOLDOFF + 3) @(negedge clk);

      // mask drop while requesting withdraws the request
      pulse(64'h200);
      wait_irq("t4_irq");
      set_mask('0);
      @(negedge clk);
      check("t4_irq_drop", 64'(o_irq), 64'h0);
      check("t4_pend_kept", 64'(o_pending), 64'h200);
      set_mask('1);
      wait_irq("t4_irq2");
      do_ack(64'h200, 1);
      repeat (HOLDOFF + 3) @(negedge clk);

      // held source sets once; iack during hold-off is ignored
      i_src[3] = 1'b1;
      wait_irq("t5_irq");
      do_ack(64'h8, 1);
      @(negedge clk);
      i_iack = 1'b1; i_src[4] = 1'b1;
      @(negedge clk);
      i_iack = 1'b0; i_src[4] = 1'b0;
      repeat (13) @(negedge clk);
      i_src[3] = 1'b0;
      wait_irq("t5_irq2");
      do_ack(64'h10, 1);
      check("t5_pend_clear", 64'(o_pending), 64'h0);
      repeat (HOLDOFF + 3) @(negedge clk);

      // asynchronous reset in the middle of an acknowledge
      pulse(64'h2);
      wait_irq("t6_irq");
      exp_q.push_back(64'h2);
      i_iack = 1'b1;
      @(negedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("t6_irq", 64'(o_irq), 64'h0);
      check("t6_vector", o_vector, 64'h0);
      check("t6_pending", 64'(o_pending), 64'h0);
      check("t6_mask", 64'(o_mask), 64'h0);
      @(negedge clk);
      reset_n = 1'b1; i_iack = 1'b0;
      @(negedge clk);
      check("t6_idle", 64'(o_irq), 64'h0);

      // randomized traffic against the model
      set_mask({$urandom(), $urandom()});
      repeat (1500) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            idx = $urandom_range(0, NIRQ - 1);
            i_src[idx] = ~i_src[idx];
         end
         i_mask_we = ($urandom_range(0, 19) == 0);
         if (i_mask_we) i_mask = ($urandom_range(0, 3) == 0) ? '0 : {$urandom(), $urandom()};
         if (left > 0) begin
            left--;
         end else if (o_irq && $urandom_range(0, 1) == 1) begin
            exp_q.push_back(64'(m_pend & m_mask));
            i_iack = 1'b1;
            left = $urandom_range(0, 2);
         end else begin
            i_iack = !o_irq && ($urandom_range(0, 15) == 0);
         end
      end
      @(negedge clk);
      i_iack = 1'b0; i_mask_we = 1'b0; i_src = '0;
      repeat (20) @(negedge clk);
      check("sb_drain", 64'(exp_q.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
